rx_frame_writer: RTL and testbench
==================================

Name: rx_frame_writer

Overview:
- Upstream stage of the internal dual-port frame buffer (64-bit, 2**AW words).
- Accepts 64-bit AXI-Stream frames from the MAC RX path and writes them into the buffer's write port (registered address and data, write every cycle, no write enable).
- Each frame is prefixed with a length header word. Only good frames are committed to the downstream reader through a word pointer.
- Frames that are bad, oversized or do not fit are discarded and never exposed to the reader.

Parameters:
- AW, 10, buffer address width; buffer depth is 2**AW words of 64 bits.
- MAX_FRAME_WORDS, 190, maximum data words per frame, excluding the header.

Ports:
- clk  in  1  single clock; also clocks the buffer write port.
- reset_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  64  frame data.
- s_axis_tkeep  in  8  byte enables; contiguous from bit 0; 0xFF on every non-last beat.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tuser  in  1  sampled on the tlast beat; 1 = good frame.
- s_axis_tready  out  1  beat accepted when tvalid && tready.
- buf_a  out  AW  buffer write address.
- buf_d  out  64  buffer write data.
- rd_ptr  in  AW+1  reader's consumed-word pointer, free-running and wrapping modulo 2**(AW+1).
- commit_ptr  out  AW+1  words committed; frames lie in [rd_ptr, commit_ptr).

Behaviour:
- Reset: state IDLE, commit_ptr=0, wr_ptr=0, s_axis_tready=0, buf_a=0, buf_d=0.
- The buffer writes buf_d to buf_a on every clock. Every cycle not writing a valid word parks buf_a on a slot that is not committed.
- Occupancy is commit_ptr-rd_ptr, computed modulo 2**(AW+1).
- Free space is 2**AW-1-occupancy. One slot always stays empty, so parked writes can never hit unread data.
- State IDLE:
  - s_axis_tready=1; buf_a=commit_ptr[AW-1:0] (parked).
  - On the first accepted beat, check free >= MAX_FRAME_WORDS+1.
  - If the check passes: header slot hdr=commit_ptr, wr_ptr=commit_ptr+1. Write the beat at wr_ptr and set bytes=popcount(tkeep). Go to WRITE, or to HEADER if tlast.
  - If the check fails: go to DROP, or stay in IDLE if tlast. Raise the drop event.
- State WRITE:
  - Each accepted beat writes to the next wr_ptr (buf_a = wr_ptr[AW-1:0]); bytes += popcount(tkeep).
  - While tvalid is low, buf_a parks on the next unused wr_ptr.
  - If a beat would exceed MAX_FRAME_WORDS: rewind wr_ptr, raise the drop event, go to DROP (or to IDLE if that beat is tlast).
  - On tlast: if tuser=1, go to HEADER. If tuser=0, rewind wr_ptr, raise the drop event, go to IDLE.
- State HEADER (1 cycle):
  - s_axis_tready=0.
  - buf_a=hdr[AW-1:0]; buf_d = {48'b0, bytes[15:0]}.
  - Schedule commit_ptr <= hdr+1+data_words, then go to IDLE.
- State DROP: s_axis_tready=1; beats are discarded and buf_a stays parked. Go to IDLE on tlast.
- Commit latency:
  - The buffer write port adds 2 cycles (address/data register, then RAM write).
  - commit_ptr updates exactly 3 cycles after the HEADER cycle, through a 3-deep delay pipe.
  - A new frame may start while a commit is pending. The admission check uses the pending commit value.
- Wrap-around: addresses use wr_ptr[AW-1:0]. A frame may straddle address 2**AW-1 → 0.
- s_axis_tready is low only in HEADER and during reset. Back-to-back frames cost 1 bubble each.
- Reset mid-frame discards the frame and anything pending. The upstream must restart at a frame boundary.

Optional Feature:
- Macro: RX_DROP_CNT_EN.
- Defined: adds output drop_cnt (32 bits, reset 0). It increments by 1 per drop event (no space, oversized, bad tuser) and saturates at 0xFFFFFFFF.
- Undefined: port and counter are absent; drop behaviour is unchanged.

Decomposition:
- Shared package/include holds:
  - state encodings (IDLE, WRITE, HEADER, DROP);
  - the header word layout (length in [15:0]);
  - HDR_WORDS=1;
  - the commit delay constant COMMIT_LAT=3.
- One sub-module is natural: rx_keep_popcnt, a combinational 8-bit tkeep → 4-bit byte count.

Test Plan:
1. Good 64-byte frame (8 beats, last tkeep 0xFF, tuser=1) from reset → buf addr 0 = 64, data at 1..8, commit_ptr 0→9 exactly 3 cycles after HEADER.
2. Good 61-byte frame (last tkeep 0x1F) → header 61, commit_ptr += 9.
3. Frame with tuser=0 on tlast → commit_ptr unchanged; next good frame's header lands at the same hdr slot.
4. rd_ptr held at 0 while frames stream in until free < 191 → following frame dropped, tready stays 1, drop_cnt (if enabled) +1. Release rd_ptr → next frame accepted.
5. Wrap-around: commit_ptr=1020, 8-word frame → header at 1020, data at 1021..1023 and 0..4, commit_ptr=1029.
6. 191-beat frame → drop on beat 191, commit unchanged. Also assert reset_n mid-frame → all outputs return to reset values immediately.

Source files
------------

// File: rtl/rx_frame_writer_pkg.sv
// Shared types and constants for the RX frame writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, header word layout, header size and commit delay.
package rx_frame_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_HEADER = 2'd2,
    ST_DROP   = 2'd3
  } state_e;

  // Length header placed in the slot in front of each committed frame.
  typedef struct packed {
    logic [47:0] rsvd;
    logic [15:0] len;   // frame length in bytes
  } hdr_t;

  localparam int HDR_WORDS  = 1;
  // Cycles from the HEADER cycle until commit_ptr moves: two for the buffer
  // write port (address/data register, RAM write) plus one of margin.
  localparam int COMMIT_LAT = 3;

  function automatic hdr_t make_hdr(input logic [15:0] len);
    hdr_t h;
    h.rsvd = '0;
    h.len  = len;
    return h;
  endfunction

endpackage

// File: rtl/rx_frame_writer_if.sv
// 64-bit AXI-Stream beat bundle from the MAC RX path into the frame writer.
// Latency: n/a (wiring only).
// Backpressure: beat transfers when tvalid && tready.
// Signals: tdata/tkeep/tvalid/tlast/tuser driven by master, tready by slave.
interface rx_frame_writer_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tuser;
  logic        tready;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/rx_keep_popcnt.sv
// Counts the valid bytes of a beat from its tkeep mask.
// Latency: combinational.
// Backpressure: none.
// Ports: keep (8-bit byte enables) -> cnt (0..8).
module rx_keep_popcnt (
  input  logic [7:0] keep,
  output logic [3:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, keep[i]};
    end
  end
endmodule

// File: rtl/rx_frame_writer.sv
// Writes RX frames into the frame buffer behind a length header; commits only good frames.
// Latency: buffer write 1 cycle after beat acceptance; commit_ptr moves 3 cycles after HEADER.
// Backpressure: tready low only in the HEADER cycle and in reset; no-space frames are dropped.
// Ports: clk, reset_n (async active-low), s_axis (AXI-Stream slave), buf_a/buf_d (buffer
//   write port, written every clock), rd_ptr (reader pointer in), commit_ptr (committed words out).
// Optional: define RX_DROP_CNT_EN to add a saturating 32-bit drop_cnt output.
module rx_frame_writer
  import rx_frame_writer_pkg::*;
#(
  parameter int AW              = 10,
  parameter int MAX_FRAME_WORDS = 190
) (
  input  logic              clk,
  input  logic              reset_n,
  rx_frame_writer_if.slave  s_axis,
  output logic [AW-1:0]     buf_a,
  output logic [63:0]       buf_d,
  input  logic [AW:0]       rd_ptr,
  output logic [AW:0]       commit_ptr
`ifdef RX_DROP_CNT_EN
  ,
  output logic [31:0]       drop_cnt
`endif
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] MAX_W   = (AW+1)'(MAX_FRAME_WORDS);
  // Frame is admitted when occupancy <= 2**AW - 1 - (MAX_FRAME_WORDS + HDR_WORDS),
  // i.e. when free space can hold a maximum frame plus its header.
  localparam logic [AW:0] OCC_LIMIT = (AW+1)'((1 << AW) - 1 - HDR_WORDS - MAX_FRAME_WORDS);

  state_e      state, state_nxt;
  logic [AW:0] wr_ptr, wr_ptr_nxt;
  logic [AW:0] hdr_ptr, hdr_ptr_nxt;
  // End of everything written so far, including frames whose commit is still
  // in the delay pipe. Admission, header placement and parking all use it so a
  // pending frame is never overwritten.
  logic [AW:0] alloc_ptr, alloc_ptr_nxt;
  logic [15:0] bytes, bytes_nxt;
  logic [AW-1:0] buf_a_nxt;
  logic [63:0]   buf_d_nxt;
  logic          tready_q;
  logic          commit_push;
  logic [AW:0]   commit_val;
  logic          drop_evt;
  logic [3:0]    keep_cnt;
  logic          beat;
  logic [AW:0]   occ;
  logic          fits;
  logic          over;
  logic [AW:0]   wr_ptr_p1;
  logic [AW:0]   alloc_p1;
  logic [AW:0]   data_words;

  logic [COMMIT_LAT-2:0] pipe_vld;
  logic [AW:0]           pipe_ptr [COMMIT_LAT-1];

  rx_keep_popcnt u_popcnt (
    .keep (s_axis.tkeep),
    .cnt  (keep_cnt)
  );

  assign s_axis.tready = tready_q;
  assign beat       = s_axis.tvalid && tready_q;
  assign occ        = alloc_ptr - rd_ptr;
  assign fits       = (occ <= OCC_LIMIT);
  assign wr_ptr_p1  = wr_ptr + PTR_ONE;
  assign alloc_p1   = alloc_ptr + PTR_ONE;
  assign data_words = wr_ptr - hdr_ptr;
  assign over       = (data_words >= MAX_W);

  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    hdr_ptr_nxt   = hdr_ptr;
    alloc_ptr_nxt = alloc_ptr;
    bytes_nxt     = bytes;
    buf_a_nxt     = alloc_ptr[AW-1:0];   // parked on the first unallocated slot
    buf_d_nxt     = buf_d;
    commit_push   = 1'b0;
    commit_val    = wr_ptr_p1;
    drop_evt      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (beat) begin
          if (fits) begin
            hdr_ptr_nxt = alloc_ptr;
            wr_ptr_nxt  = alloc_p1;
            bytes_nxt   = {12'b0, keep_cnt};
            buf_a_nxt   = alloc_p1[AW-1:0];
            buf_d_nxt   = s_axis.tdata;
            if (!s_axis.tlast) begin
              state_nxt = ST_WRITE;
            end else if (s_axis.tuser) begin
              state_nxt = ST_HEADER;
            end else begin
              wr_ptr_nxt = alloc_ptr;
              drop_evt   = 1'b1;
            end
          end else begin
            drop_evt = 1'b1;
            if (!s_axis.tlast) state_nxt = ST_DROP;
          end
        end
      end

      ST_WRITE: begin
        buf_a_nxt = wr_ptr_p1[AW-1:0];   // idle cycles park on the next unused slot
        if (beat) begin
          if (over) begin
            wr_ptr_nxt = hdr_ptr;
            drop_evt   = 1'b1;
            buf_a_nxt  = alloc_ptr[AW-1:0];
            state_nxt  = s_axis.tlast ? ST_IDLE : ST_DROP;
          end else begin
            wr_ptr_nxt = wr_ptr_p1;
            bytes_nxt  = bytes + {12'b0, keep_cnt};
            buf_d_nxt  = s_axis.tdata;
            if (s_axis.tlast) begin
              if (s_axis.tuser) begin
                state_nxt = ST_HEADER;
              end else begin
                wr_ptr_nxt = hdr_ptr;
                drop_evt   = 1'b1;
                state_nxt  = ST_IDLE;
              end
            end
          end
        end
      end

      ST_HEADER: begin
        buf_a_nxt     = hdr_ptr[AW-1:0];
        buf_d_nxt     = make_hdr(bytes);
        commit_push   = 1'b1;
        commit_val    = wr_ptr_p1;
        alloc_ptr_nxt = wr_ptr_p1;
        state_nxt     = ST_IDLE;
      end

      ST_DROP: begin
        if (beat && s_axis.tlast) state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      hdr_ptr   <= '0;
      alloc_ptr <= '0;
      bytes     <= '0;
      buf_a     <= '0;
      buf_d     <= '0;
      tready_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      hdr_ptr   <= hdr_ptr_nxt;
      alloc_ptr <= alloc_ptr_nxt;
      bytes     <= bytes_nxt;
      buf_a     <= buf_a_nxt;
      buf_d     <= buf_d_nxt;
      tready_q  <= (state_nxt != ST_HEADER);
    end
  end

  // Commit delay: two pipe stages plus the commit_ptr register itself, so the
  // header's RAM write has landed before the reader can see the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_vld   <= '0;
      for (int i = 0; i < COMMIT_LAT-1; i++) pipe_ptr[i] <= '0;
      commit_ptr <= '0;
    end else begin
      pipe_vld[0] <= commit_push;
      pipe_ptr[0] <= commit_val;
      for (int i = 1; i < COMMIT_LAT-1; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_ptr[i] <= pipe_ptr[i-1];
      end
      if (pipe_vld[COMMIT_LAT-2]) commit_ptr <= pipe_ptr[COMMIT_LAT-2];
    end
  end

`ifdef RX_DROP_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (drop_evt && (drop_cnt != 32'hFFFF_FFFF)) begin
      drop_cnt <= drop_cnt + 32'd1;
    end
  end
`else
  logic unused_drop_evt;
  assign unused_drop_evt = drop_evt;
`endif

endmodule

// File: tb/tb_rx_frame_writer.sv
// Randomized scoreboard bench for rx_frame_writer.
// Latency: n/a.
// Backpressure: n/a.
module tb_rx_frame_writer;
  localparam int AW  = 10;
  localparam int MAX = 190;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [AW:0] hdr;
    logic [AW:0] endp;
    logic [15:0] len;
    logic [15:0] nwords;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] buf_a;
  logic [63:0]   buf_d;
  logic [AW:0]   rd_ptr = '0;
  logic [AW:0]   commit_ptr;
`ifdef RX_DROP_CNT_EN
  logic [31:0]   drop_cnt;
`endif

  rx_frame_writer_if axis();

  rx_frame_writer #(.AW(AW), .MAX_FRAME_WORDS(MAX)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_axis     (axis),
    .buf_a      (buf_a),
    .buf_d      (buf_d),
    .rd_ptr     (rd_ptr),
    .commit_ptr (commit_ptr)
`ifdef RX_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural frame buffer: one write per clock from the registered port.
  logic [63:0] mem [0:DEPTH-1];
  always @(posedge clk) mem[buf_a] <= buf_d;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic mon_en = 1'b0;
  logic [AW:0] last_commit = '0;

  // Reference model state
  logic [AW:0] m_alloc = '0;
  int          m_drops = 0;
  exp_t        exp_q[$];
  logic [63:0] exp_words[$];
  int          hdr_cyc_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  function automatic int model_free();
    logic [AW:0] d;
    d = m_alloc - rd_ptr;
    return DEPTH - 1 - int'(d);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT publishes a new commit.
  always @(negedge clk) begin : mon
    exp_t e;
    logic [AW:0] a;
    cyc = cyc + 1;
    if (mon_en) begin
      if (!axis.tready) hdr_cyc_q.push_back(cyc);
      if (commit_ptr != last_commit) begin
        last_commit = commit_ptr;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_commit: commit_ptr=%0d with no frame expected", commit_ptr);
        end else begin
          e = exp_q.pop_front();
          chk("commit_ptr", 64'(commit_ptr), 64'(e.endp));
          chk("hdr_word", mem[e.hdr[AW-1:0]], {48'b0, e.len});
          for (int i = 0; i < int'(e.nwords); i++) begin
            a = e.hdr + (AW+1)'(i + 1);
            chk("data_word", mem[a[AW-1:0]], exp_words.pop_front());
          end
          if (hdr_cyc_q.size() == 0) begin
            n_checks++;
            $display("FAIL commit_latency: commit with no HEADER cycle seen");
          end else begin
            chk("commit_latency", 64'(cyc - hdr_cyc_q.pop_front()), 64'd3);
          end
        end
      end
    end
  end

  task automatic send_frame(input int n, input logic [7:0] last_keep, input logic good,
                            input int gap_pct, output int lowcnt);
    logic [63:0] w[$];
    int   i, waits, bytes;
    logic admit;
    exp_t e;
    admit  = (model_free() >= MAX + 1);
    lowcnt = 0;
    for (int k = 0; k < n; k++) w.push_back({$urandom, $urandom});
    i = 0;
    waits = 0;
    while (i < n && waits < 4 * n + 200) begin
      @(negedge clk);
      waits++;
      if (!axis.tready) lowcnt++;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        axis.tvalid = 1'b0;
      end else begin
        axis.tvalid = 1'b1;
        axis.tdata  = w[i];
        axis.tkeep  = (i == n - 1) ? last_keep : 8'hFF;
        axis.tlast  = (i == n - 1);
        axis.tuser  = (i == n - 1) ? good : 1'($urandom);
        if (axis.tready) i++;
      end
    end
    if (i < n) begin
      n_checks++;
      $display("FAIL send_timeout: sent %0d of %0d beats", i, n);
    end
    @(negedge clk);
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    bytes = (n - 1) * 8 + $countones(last_keep);
    if (!admit || n > MAX || !good) begin
      m_drops++;
    end else begin
      e.hdr    = m_alloc;
      e.nwords = 16'(n);
      e.len    = 16'(bytes);
      e.endp   = m_alloc + (AW+1)'(n + 1);
      exp_q.push_back(e);
      foreach (w[k]) exp_words.push_back(w[k]);
      m_alloc = e.endp;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (4) @(negedge clk);
    chk("commit_idle", 64'(commit_ptr), 64'(m_alloc));
`ifdef RX_DROP_CNT_EN
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
`endif
  endtask

  task automatic check_reset_outputs();
    chk("rst_buf_a", 64'(buf_a), 64'd0);
    chk("rst_buf_d", buf_d, 64'd0);
    chk("rst_commit_ptr", 64'(commit_ptr), 64'd0);
    chk("rst_tready", 64'(axis.tready), 64'd0);
`ifdef RX_DROP_CNT_EN
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
  endtask

  task automatic leave_reset();
    m_alloc = '0;
    m_drops = 0;
    exp_q.delete();
    exp_words.delete();
    hdr_cyc_q.delete();
    last_commit = '0;
    rd_ptr = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1 mon_en = 1'b1;
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int low, rem, n;
    logic [7:0] keep;
    logic good;
    logic [AW:0] occ;
    axis.tvalid = 1'b0;
    axis.tdata  = '0;
    axis.tkeep  = '0;
    axis.tlast  = 1'b0;
    axis.tuser  = 1'b0;

    #12 check_reset_outputs();
    leave_reset();

    // 1: 64-byte good frame from reset
    send_frame(8, 8'hFF, 1'b1, 0, low);
    drain();
    chk("t1_commit", 64'(commit_ptr), 64'd9);
    chk("t1_hdr", mem[0], 64'd64);

    // 2: 61-byte frame
    send_frame(8, 8'h1F, 1'b1, 20, low);
    drain();
    chk("t2_commit", 64'(commit_ptr), 64'd18);
    chk("t2_hdr", mem[9], 64'd61);

    // 3: bad frame, then good frame reuses the same header slot
    send_frame(5, 8'h0F, 1'b0, 0, low);
    send_frame(2, 8'h03, 1'b1, 0, low);
    drain();
    chk("t3_commit", 64'(commit_ptr), 64'd21);
    chk("t3_hdr", mem[18], 64'd10);

    // 4: reader stalled until space runs out
    while (model_free() >= MAX + 1) send_frame(20, 8'hFF, 1'b1, 0, low);
    drain();
    send_frame(12, 8'hFF, 1'b1, 0, low);
    chk("t4_tready_during_drop", 64'(low), 64'd0);
    drain();
    rd_ptr = m_alloc;
    send_frame(6, 8'h7F, 1'b1, 10, low);
    drain();

    // 5: steer the allocation point to 1020 and straddle the wrap
    rem = (1020 - int'(m_alloc[AW-1:0]) + DEPTH) % DEPTH;
    while (rem != 0) begin
      n = (rem > 150 || rem == 1) ? 100 : rem - 1;
      send_frame(n, 8'hFF, 1'b1, 0, low);
      drain();
      rd_ptr = m_alloc;
      rem = (1020 - int'(m_alloc[AW-1:0]) + DEPTH) % DEPTH;
    end
    send_frame(8, 8'hFF, 1'b1, 15, low);
    drain();
    chk("t5_hdr", mem[1020], 64'd64);
    chk("t5_commit_low", 64'(commit_ptr[AW-1:0]), 64'd5);
    rd_ptr = m_alloc;

    // 6: oversized frame is dropped, commit unchanged
    send_frame(MAX + 1, 8'hFF, 1'b1, 0, low);
    drain();

    // random traffic
    for (int f = 0; f < 60; f++) begin
      n    = ($urandom_range(9) == 0) ? $urandom_range(150, MAX) : $urandom_range(1, 24);
      keep = 8'hFF;
      keep = keep >> $urandom_range(7);
      good = ($urandom_range(5) != 0);
      send_frame(n, keep, good, $urandom_range(30), low);
      if ($urandom_range(3) == 0) begin
        drain();
        occ = m_alloc - rd_ptr;
        rd_ptr = rd_ptr + (AW+1)'($urandom_range(int'(occ)));
      end
    end
    drain();

    // reset in the middle of a frame
    rd_ptr = m_alloc;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      axis.tvalid = 1'b1;
      axis.tdata  = {$urandom | 32'h1, $urandom};
      axis.tkeep  = 8'hFF;
      axis.tlast  = 1'b0;
    end
    @(negedge clk);
    mon_en = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_reset_outputs();
    axis.tvalid = 1'b0;
    leave_reset();
    send_frame(4, 8'hFF, 1'b1, 0, low);
    drain();
    chk("post_reset_commit", 64'(commit_ptr), 64'd5);
    chk("post_reset_hdr", mem[0], 64'd32);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
